// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: owns HI/LO, runs the latency counter
// and raises m_stall while an md-class instruction in D must wait.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    input  logic        D_md,
    output logic        busy,
    output logic        m_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic [31:0] r_pend_hi, r_pend_lo, w_pend_hi_nxt, w_pend_lo_nxt;
    logic [63:0] w_result;
    logic        w_go;
    logic        w_is_calc;

    // Full 64-bit {HI, LO} result; division by zero yields LO=all-ones, HI=dividend.
    function automatic logic [63:0] f_md_result(input logic [2:0] f_op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] prod;
        logic [31:0] ma, mb, uq, ur, q, r;
        prod = '0;
        ma   = a;
        mb   = b;
        q    = '0;
        r    = '0;
        case (f_op)
            OP_MULT:  prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            OP_MULTU: prod = {32'd0, a} * {32'd0, b};
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    r = a;
                end else if (f_op == OP_DIV) begin
                    // Divide magnitudes, then restore signs (C-style truncation).
                    ma = a[31] ? -a : a;
                    mb = b[31] ? -b : b;
                    uq = ma / mb;
                    ur = ma % mb;
                    q  = (a[31] ^ b[31]) ? -uq : uq;
                    r  = a[31] ? -ur : ur;
                end else begin
                    q = a / b;
                    r = a % b;
                end
                prod = {r, q};
            end
            default: prod = '0;
        endcase
        return prod;
    endfunction

    assign w_result  = f_md_result(op, A, B);
    assign w_is_calc = ~op[2];
    assign w_go      = start & ~cancel & (r_state == IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    if (w_is_calc) begin
                        w_pend_hi_nxt = w_result[63:32];
                        w_pend_lo_nxt = w_result[31:0];
                        w_cnt_nxt     = op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                        w_state_nxt   = BUSY;
                    end else if (op == OP_MTHI) begin
                        w_hi_nxt = A;
                    end else if (op == OP_MTLO) begin
                        w_lo_nxt = A;
                    end
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - 5'd1;
                if (r_cnt == 5'd1) begin
                    w_hi_nxt    = r_pend_hi;
                    w_lo_nxt    = r_pend_lo;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
        end
    end

    // Stall covers the accepting cycle as well as every busy cycle.
    assign busy    = (r_state == BUSY);
    assign m_stall = D_md & (busy | (start & ~cancel & w_is_calc));
    assign HI      = r_hi;
    assign LO      = r_lo;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO/latency queued at issue,
// popped and compared by a monitor when busy falls.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        cancel = 1'b0;
    logic        D_md = 1'b0;
    logic        busy, m_stall;
    logic [31:0] HI, LO;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .D_md(D_md), .busy(busy), .m_stall(m_stall),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Monitor: count busy cycles, compare on the busy falling edge.
    int busy_cnt  = 0;
    bit prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_busy && !busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("HI", {32'd0, HI}, {32'd0, e.hi});
                    chk("LO", {32'd0, LO}, {32'd0, e.lo});
                    chk("latency", 64'(busy_cnt), 64'(e.n));
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic expect_res(input logic [31:0] hi, input logic [31:0] lo, input int n);
        exp_t e;
        e.hi = hi; e.lo = lo; e.n = n;
        q.push_back(e);
        m_hi = hi;
        m_lo = lo;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            chk("timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] stall_v;
        logic       any_stall;

        // Reset state and idle behaviour with D_md asserted.
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        D_md = 1'b1;
        any_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            any_stall = any_stall | m_stall | busy;
        end
        chk("reset_HI", {32'd0, HI}, 64'd0);
        chk("reset_LO", {32'd0, LO}, 64'd0);
        chk("idle_stall_busy", {63'd0, any_stall}, 64'd0);
        D_md = 1'b0;

        // mult / multu / div / divu vectors.
        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);  issue(3'd0, 32'hFFFF_FFFE, 32'd3); wait_done();
        expect_res(32'h0000_0002, 32'hFFFF_FFFA, 5);  issue(3'd1, 32'hFFFF_FFFE, 32'd3); wait_done();
        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10); issue(3'd2, 32'hFFFF_FFF9, 32'd2); wait_done();
        expect_res(32'h0000_0001, 32'hFFFF_FFFD, 10); issue(3'd2, 32'd7, 32'hFFFF_FFFE); wait_done();
        expect_res(32'h0000_0007, 32'hFFFF_FFFF, 10); issue(3'd3, 32'd7, 32'd0);         wait_done();
        expect_res(32'h0000_0002, 32'h0000_000E, 10); issue(3'd3, 32'd100, 32'd7);       wait_done();
        expect_res(32'h0000_0000, 32'h8000_0000, 10); issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        expect_res(32'hFFFF_FFFB, 32'hFFFF_FFFF, 10); issue(3'd2, 32'hFFFF_FFFB, 32'd0); wait_done();

        // mtlo / mthi: next edge, no busy.
        issue(3'd5, 32'h0000_1234, 32'd0);
        @(negedge clk);
        chk("mtlo_LO", {32'd0, LO}, 64'h1234);
        chk("mtlo_HI", {32'd0, HI}, {32'd0, m_hi});
        chk("mtlo_busy", {63'd0, busy}, 64'd0);
        m_lo = 32'h0000_1234;
        issue(3'd4, 32'h0000_CAFE, 32'd0);
        @(negedge clk);
        chk("mthi_HI", {32'd0, HI}, 64'hCAFE);
        chk("mthi_LO", {32'd0, LO}, 64'h1234);
        m_hi = 32'h0000_CAFE;

        // start with cancel: suppressed, no stall even with D_md.
        @(posedge clk); #1;
        start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd5; cancel = 1'b1; D_md = 1'b1;
        @(negedge clk);
        chk("cancel_stall", {63'd0, m_stall}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0; D_md = 1'b0;
        @(negedge clk);
        chk("cancel_busy", {63'd0, busy}, 64'd0);
        chk("cancel_HI", {32'd0, HI}, {32'd0, m_hi});
        chk("cancel_LO", {32'd0, LO}, {32'd0, m_lo});

        // cancel pulsed mid-operation: result still committed on schedule.
        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        repeat (3) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        wait_done();

        // Stall window with D_md held: start cycle + MULT_CYCLES.
        expect_res(32'h0000_0000, 32'h0000_0015, 5);
        @(posedge clk); #1;
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd7; D_md = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stall_v[i] = m_stall;
            @(posedge clk); #1;
            start = 1'b0;
        end
        D_md = 1'b0;
        chk("stall_window", {54'd0, stall_v}, 64'h03F);
        wait_done();

        // D_md low: never stall.
        expect_res(32'h0000_0000, 32'h0000_0000, 5);
        @(posedge clk); #1;
        start = 1'b1; op = 3'd1; A = 32'd0; B = 32'd9;
        any_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any_stall = any_stall | m_stall;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("no_dmd_stall", {63'd0, any_stall}, 64'd0);
        wait_done();

        // start while busy is ignored.
        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (15) @(negedge clk);
        chk("ignored_busy", {63'd0, busy}, 64'd0);
        chk("ignored_HI", {32'd0, HI}, 64'hFFFF_FFFF);
        chk("ignored_LO", {32'd0, LO}, 64'hFFFF_FFFA);

        // Asynchronous reset mid-div clears outputs without a clock edge.
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_HI", {32'd0, HI}, 64'd0);
        chk("async_rst_LO", {32'd0, LO}, 64'd0);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_LO", {32'd0, LO}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
